text_overlay_scheduler: RTL and testbench
=========================================

Name: text_overlay_scheduler

Overview:
Sequences the per-pixel text banner generators for the VGA demo. It shares one overlay output between up to four banner sources using round-robin selection over an enable mask. Each selected banner plays a frame-timed show cycle: slide-in, steady, blink-out, gap. It outputs the registered overlay pixel, the selected source index and a vertical slide offset that the banner modules subtract from their row origin.

Parameters:
NUM_SRC, 4, number of banner sources (2..4); sel width fixed at 2 bits
GAP_FRAMES, 15, blank frames between banners (1..255)
SLIDE_ROWS, 8, initial y_shift value at slide-in start (1..63)
SHOW_FRAMES, 120, steady frames (1..255)
BLINK_FRAMES, 32, blink-out frames (1..255)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at the start of each frame (x=0, y=0)
src_en  in  NUM_SRC  per-source enable mask, may change any cycle
skip  in  1  level/pulse request to end the current banner early
overlay_in  in  NUM_SRC  combinational overlay_active bits from the banner modules for the current pixel
overlay_active  out  1  registered gated overlay pixel
sel  out  2  index of the currently scheduled source
y_shift  out  6  slide offset in 8-pixel text rows; 0 = final position
busy  out  1  high in SLIDE, SHOW or BLINK

Behaviour:
- Reset (async assert, sync release): state=GAP, frame_cnt=0, sel=0, rr_last=NUM_SRC-1, y_shift=0, skip_pend=0, overlay_active=0, busy=0.
- frame_cnt is 8 bits. It advances only on the cycle frame_start=1 and is cleared on every state transition.
- GAP: y_shift=0 and no pixels output. On a frame_start where frame_cnt==GAP_FRAMES-1, search for the first enabled source at indices rr_last+1, rr_last+2, … (mod NUM_SRC), checking all NUM_SRC positions, including rr_last.
  - If a source is found: sel←found, rr_last←found, y_shift←SLIDE_ROWS, go to SLIDE.
  - If none is found: stay in GAP, clear frame_cnt and retry after another GAP_FRAMES frames.
- SLIDE: on each frame_start, y_shift decrements by 1. On the frame_start where y_shift==1, y_shift becomes 0 and the state goes to SHOW.
- SHOW: go to BLINK on the frame_start where frame_cnt==SHOW_FRAMES-1.
- BLINK: the output is visible when frame_cnt[2]==0, giving 4 frames on and 4 frames off. Go to GAP on the frame_start where frame_cnt==BLINK_FRAMES-1.
- Pixel path: overlay_active ← overlay_in[sel] & vis, registered (1-cycle latency).
  - vis=1 in SLIDE and SHOW.
  - vis=!frame_cnt[2] in BLINK.
  - vis=0 in GAP.
  - Index sel out of range (≥NUM_SRC) gives 0.
- Enable drop: if src_en[sel]==0 while busy, the next clock goes to GAP (frame_cnt=0, y_shift=0). overlay_active is 0 from the following cycle.
- skip:
  - A skip=1 cycle while busy sets skip_pend.
  - At the next frame_start, skip_pend forces GAP and clears itself; this takes precedence over any normal transition at that frame_start.
  - skip in GAP is ignored and does not set skip_pend.
- sel and y_shift change only at frame_start or on an enable drop, so they are stable across the visible frame body.
- Simultaneous events in the same cycle: enable drop > skip_pend > normal transition.
- Reset mid-frame or mid-banner returns immediately to the reset values. The first banner after reset starts from index 0.

Test Plan:
1. src_en=4'b1111, GAP_FRAMES=2, SLIDE_ROWS=3, SHOW_FRAMES=4, BLINK_FRAMES=8; pulse frame_start. Required response:
   - sel=0 entering SLIDE at frame 2.
   - y_shift steps 3→2→1→0; SHOW for 4 frames; BLINK visible on 4 frames, blank on 4; then GAP.
   - Next banner has sel=1; order continues 0,1,2,3,0.
2. src_en=4'b1010: selection sequence is 1,3,1,3. src_en=0: stays in GAP, busy=0, overlay_active=0 indefinitely.
3. Pixel latency: in SHOW with sel=2, toggle overlay_in[2] each cycle and hold the other bits at 1 → overlay_active equals overlay_in[2] delayed by one cycle.
4. During SHOW, pulse skip for 1 cycle mid-frame → state unchanged until the next frame_start, then GAP with busy=0. skip during GAP → no effect.
5. Clear src_en[sel] mid-SLIDE → GAP one clock later, y_shift=0, overlay_active=0 the cycle after. Same cycle with skip_pend set → enable-drop path taken and skip_pend cleared.
6. Assert rst_n=0 asynchronously mid-BLINK with no clock edge → outputs immediately at reset values. After release, the first banner has sel=0.

Source files
------------

// File: rtl/text_overlay_scheduler.sv
// -----------------------------------------------------------------------------
// text_overlay_scheduler
//
// Shares one overlay pixel output between up to four text banner generators.
// Sources are picked round-robin from the enable mask; each picked banner runs
// a frame-timed show cycle: slide-in, steady, blink-out, then a blank gap.
//
// Ports:
//   clk            pixel clock
//   rst_n          asynchronous active-low reset
//   frame_start    one-cycle pulse at the first pixel of each frame
//   src_en         per-source enable mask (may change any cycle)
//   skip           request to end the current banner at the next frame start
//   overlay_in     per-source overlay bits for the current pixel
//   overlay_active registered, gated overlay pixel (1-cycle latency)
//   sel            index of the scheduled source
//   y_shift        slide offset in text rows, 0 = final position
//   busy           high while a banner is sliding, showing or blinking
// -----------------------------------------------------------------------------
module text_overlay_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int GAP_FRAMES   = 15,
  parameter int SLIDE_ROWS   = 8,
  parameter int SHOW_FRAMES  = 120,
  parameter int BLINK_FRAMES = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic               skip,
  input  logic [NUM_SRC-1:0] overlay_in,
  output logic               overlay_active,
  output logic [1:0]         sel,
  output logic [5:0]         y_shift,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_GAP   = 2'd0,
    ST_SLIDE = 2'd1,
    ST_SHOW  = 2'd2,
    ST_BLINK = 2'd3
  } state_t;

  localparam logic [7:0] GAP_LAST   = 8'(GAP_FRAMES - 1);
  localparam logic [7:0] SHOW_LAST  = 8'(SHOW_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [5:0] SLIDE_INIT = 6'(SLIDE_ROWS);
  localparam logic [1:0] RR_INIT    = 2'(NUM_SRC - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] frame_cnt;
  logic [1:0] rr_last;
  logic       skip_pend;

  // Source vectors padded to the full 2-bit index range; the padding bits
  // are zero, so an out-of-range sel reads as disabled / no pixel.
  logic [3:0] en4;
  logic [3:0] ov4;
  logic       en_sel;
  logic       drop;
  logic       skip_fire;
  logic       found;
  logic [1:0] found_idx;
  logic       gap_wrap;
  logic       start_banner;
  logic       vis;
  logic       pix_p0;

  // First enabled source after `last`, wrapping, with `last` itself checked
  // at the end. Bit 2 of the result flags that a source was found.
  function automatic logic [2:0] rr_search(input logic [3:0] en,
                                           input logic [1:0] last);
    logic [2:0] res;
    int         idx;
    res = 3'b000;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last) + k) % NUM_SRC;
      if (!res[2] && en[2'(idx)]) begin
        res = {1'b1, 2'(idx)};
      end
    end
    return res;
  endfunction

  assign en4                = 4'(src_en);
  assign ov4                = 4'(overlay_in);
  assign en_sel             = en4[sel];
  assign drop               = busy & ~en_sel;
  assign skip_fire          = frame_start & skip_pend;
  assign {found, found_idx} = rr_search(en4, rr_last);
  assign gap_wrap           = (state == ST_GAP) && frame_start && (frame_cnt == GAP_LAST);
  assign start_banner       = (state == ST_GAP) && (state_nxt == ST_SLIDE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_GAP;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; later assignments override earlier ones, giving
  // enable drop > pending skip > normal frame-timed transition.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_GAP:   if (gap_wrap && found)                            state_nxt = ST_SLIDE;
      ST_SLIDE: if (frame_start && (y_shift == 6'd1))             state_nxt = ST_SHOW;
      ST_SHOW:  if (frame_start && (frame_cnt == SHOW_LAST))      state_nxt = ST_BLINK;
      ST_BLINK: if (frame_start && (frame_cnt == BLINK_LAST))     state_nxt = ST_GAP;
      default:                                                    state_nxt = ST_GAP;
    endcase
    if (skip_fire) state_nxt = ST_GAP;
    if (drop)      state_nxt = ST_GAP;
  end

  // Output decode; blink-out shows 4 frames on, 4 frames off.
  always_comb begin
    busy = 1'b0;
    vis  = 1'b0;
    case (state)
      ST_SLIDE, ST_SHOW: begin
        busy = 1'b1;
        vis  = 1'b1;
      end
      ST_BLINK: begin
        busy = 1'b1;
        vis  = ~frame_cnt[2];
      end
      default: begin
        busy = 1'b0;
        vis  = 1'b0;
      end
    endcase
  end

  assign pix_p0 = ov4[sel] & vis;

  // Frame counter, scheduling registers and the pixel output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt      <= 8'd0;
      sel            <= 2'd0;
      rr_last        <= RR_INIT;
      y_shift        <= 6'd0;
      skip_pend      <= 1'b0;
      overlay_active <= 1'b0;
    end else begin
      // A failed GAP search also restarts the gap count.
      if ((state_nxt != state) || gap_wrap) begin
        frame_cnt <= 8'd0;
      end else if (frame_start) begin
        frame_cnt <= frame_cnt + 8'd1;
      end

      if (start_banner) begin
        sel     <= found_idx;
        rr_last <= found_idx;
      end

      if (state_nxt == ST_GAP) begin
        y_shift <= 6'd0;
      end else if (start_banner) begin
        y_shift <= SLIDE_INIT;
      end else if ((state == ST_SLIDE) && frame_start) begin
        y_shift <= y_shift - 6'd1;
      end

      // Pending skip survives only while a banner keeps running.
      skip_pend <= (state_nxt != ST_GAP) & (skip_pend | (skip & busy));

      overlay_active <= pix_p0;
    end
  end

endmodule

// File: tb/tb_text_overlay_scheduler.sv
// -----------------------------------------------------------------------------
// tb_text_overlay_scheduler
//
// Randomized bench for text_overlay_scheduler with short show-cycle timing.
// A phase-table reference model predicts busy, sel, y_shift and the delayed
// overlay pixel every cycle; banner start order and asynchronous reset are
// also checked against fixed expectations.
// -----------------------------------------------------------------------------
module tb_text_overlay_scheduler;

  localparam int NS  = 4;
  localparam int GF  = 2;
  localparam int SR  = 3;
  localparam int SHF = 4;
  localparam int BF  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          frame_start = 1'b0;
  logic [NS-1:0] src_en = '0;
  logic          skip = 1'b0;
  logic [NS-1:0] overlay_in = '0;
  logic          overlay_active;
  logic [1:0]    sel;
  logic [5:0]    y_shift;
  logic          busy;

  text_overlay_scheduler #(
    .NUM_SRC     (NS),
    .GAP_FRAMES  (GF),
    .SLIDE_ROWS  (SR),
    .SHOW_FRAMES (SHF),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .src_en        (src_en),
    .skip          (skip),
    .overlay_in    (overlay_in),
    .overlay_active(overlay_active),
    .sel           (sel),
    .y_shift       (y_shift),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase index 0=gap 1=slide 2=show 3=blink, frames spent
  // in the phase, and a table of phase lengths in frames.
  int         phase_len [4] = '{GF, SR, SHF, BF};
  int         m_ph, m_fr, n_ph, n_fr;
  logic [1:0] m_sel, m_last, n_sel, n_last;
  bit         m_pend, n_pend;
  bit         e_ov, n_ov;

  int fcnt = 0;
  int n_start = 0;
  bit prev_busy = 0;

  task automatic model_reset();
    m_ph = 0; m_fr = 0; m_sel = 2'd0; m_last = 2'(NS - 1); m_pend = 0; e_ov = 0;
  endtask

  task automatic model_step(input bit fs, input logic [NS-1:0] en, input bit sk,
                            input logic [NS-1:0] ovin);
    bit m_busy, vis;
    int c;
    m_busy = (m_ph != 0);
    vis    = (m_ph == 1) || (m_ph == 2) || ((m_ph == 3) && ((m_fr / 4) % 2 == 0));
    n_ov   = vis && ovin[m_sel];
    n_ph = m_ph; n_fr = m_fr; n_sel = m_sel; n_last = m_last; n_pend = m_pend;
    if (m_busy && !en[m_sel]) begin
      n_ph = 0; n_fr = 0; n_pend = 0;
    end else if (fs && m_pend && m_busy) begin
      n_ph = 0; n_fr = 0; n_pend = 0;
    end else begin
      n_pend = m_pend || (sk && m_busy);
      if (fs) begin
        if (m_fr + 1 == phase_len[m_ph]) begin
          n_fr = 0;
          if (m_ph == 0) begin
            for (int k = 1; k <= NS; k++) begin
              c = (int'(m_last) + k) % NS;
              if (n_ph == 0 && en[c]) begin
                n_ph = 1; n_sel = 2'(c); n_last = 2'(c);
              end
            end
          end else begin
            n_ph = (m_ph + 1) % 4;
          end
        end else begin
          n_fr = m_fr + 1;
        end
      end
      if (n_ph == 0) n_pend = 0;
    end
  endtask

  task automatic check_outputs(input int omode);
    int exp_order;
    chk("overlay_active", int'(overlay_active), int'(e_ov));
    chk("sel", int'(sel), int'(m_sel));
    chk("y_shift", int'(y_shift), (m_ph == 1) ? (SR - m_fr) : 0);
    chk("busy", int'(busy), int'(m_ph != 0));
    if (!prev_busy && busy && omode != 0) begin
      exp_order = (omode == 1) ? (n_start % 4) : (((n_start % 2) == 1) ? 3 : 1);
      chk("rr_order", int'(sel), exp_order);
      n_start++;
    end
    prev_busy = busy;
  endtask

  // Called right after a falling edge: asserts reset with no clock edge,
  // checks the outputs straight away, then releases at a later falling edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_overlay_active", int'(overlay_active), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_y_shift", int'(y_shift), 0);
    chk("rst_busy", int'(busy), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fcnt = 0; n_start = 0; prev_busy = 0;
  endtask

  task automatic run(input int ncyc, input int en_rate, input int sk_rate,
                     input int omode, input bit stop_blink, output bit hit);
    hit = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (fcnt == 0) begin
        frame_start = 1'b1;
        fcnt = $urandom_range(3, 8);
      end else begin
        frame_start = 1'b0;
        fcnt--;
      end
      if (en_rate > 0 && $urandom_range(0, en_rate - 1) == 0)
        src_en[$urandom_range(0, NS - 1)] ^= 1'b1;
      skip = (sk_rate > 0) && ($urandom_range(0, sk_rate - 1) == 0);
      overlay_in = NS'($urandom);
      model_step(frame_start, src_en, skip, overlay_in);
      @(posedge clk);
      m_ph = n_ph; m_fr = n_fr; m_sel = n_sel; m_last = n_last; m_pend = n_pend; e_ov = n_ov;
      @(negedge clk);
      check_outputs(omode);
      if (stop_blink && m_ph == 3 && m_fr == 2) begin
        hit = 1;
        break;
      end
    end
    frame_start = 1'b0;
    skip = 1'b0;
  endtask

  initial begin
    bit hit;
    model_reset();
    @(negedge clk);
    async_reset();

    // Full mask: banners in order 0,1,2,3,0,...
    src_en = 4'b1111;
    run(800, 0, 0, 1, 0, hit);

    // Sparse mask: 1,3,1,3
    @(negedge clk);
    async_reset();
    src_en = 4'b1010;
    run(600, 0, 0, 2, 0, hit);

    // No sources: scheduler must stay idle
    src_en = 4'b0000;
    run(300, 0, 0, 0, 0, hit);

    // Random enable drops and skips
    src_en = 4'b1111;
    run(4000, 40, 60, 0, 0, hit);
    src_en = 4'b1111;
    run(2000, 150, 25, 0, 0, hit);

    // Reset mid-blink, then the first banner must be source 0
    src_en = 4'b1111;
    run(2000, 0, 0, 0, 1, hit);
    chk("reach_blink", int'(hit), 1);
    async_reset();
    run(300, 0, 0, 1, 0, hit);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
